// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - two-port round-robin sequencer for the 4x8 dual-rail cache
//
// Purpose: grants one of two clocked requesters, drives a dual-rail codeword to the
// asynchronous cache, completes a four-phase return-to-zero handshake and reports the
// result with a one-cycle done pulse.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req*/we*/idx*/wdata*      requester command fields (held until done)
//   done0/done1, rdata, err   completion pulse, read data, error flag
//   busy                      sequencer not idle
//   c_addr/c_data_in          dual-rail index / write data to cache (0 = spacer)
//   c_read_Nwrite             [1] read request, [0] write request
//   c_ack_in_read             read data consumed
//   c_data_out                dual-rail read data from cache
//   c_ack_read/c_ack_write    asynchronous cache acknowledges
module cache_port_arbiter #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [1:0]  idx0,
   input  logic [1:0]  idx1,
   input  logic [7:0]  wdata0,
   input  logic [7:0]  wdata1,
   output logic        done0,
   output logic        done1,
   output logic [7:0]  rdata,
   output logic        err,
   output logic        busy,
   output logic [3:0]  c_addr,
   output logic [15:0] c_data_in,
   output logic [1:0]  c_read_Nwrite,
   output logic        c_ack_in_read,
   input  logic [15:0] c_data_out,
   input  logic        c_ack_read,
   input  logic        c_ack_write
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_DRIVE    = 3'd1;
   localparam logic [2:0] S_WAIT_ACK = 3'd2;
   localparam logic [2:0] S_RTZ      = 3'd3;
   localparam logic [2:0] S_WAIT_REL = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   logic [2:0]             state, state_next;
   logic                   last_grant, gnt_q, we_q, err_flag;
   logic [CW-1:0]          cnt;
   logic [SYNC_STAGES-1:0] sync_r, sync_w;
   logic                   ack_r_s, ack_w_s, ack_sel, timeout_hit;
   logic                   grant_any, grant_port;
   logic                   sel_we;
   logic [1:0]             sel_idx;
   logic [7:0]             sel_wdata;
   logic [7:0]             rd_dec;
   logic                   rd_bad;

   function automatic logic [15:0] enc8(input logic [7:0] d);
      logic [15:0] r;
      for (int k = 0; k < 8; k++) begin
         r[2*k+1] = d[k];
         r[2*k]   = ~d[k];
      end
      return r;
   endfunction

   assign ack_r_s     = sync_r[SYNC_STAGES-1];
   assign ack_w_s     = sync_w[SYNC_STAGES-1];
   assign ack_sel     = we_q ? ack_w_s : ack_r_s;
   assign timeout_hit = (cnt == CW'(TIMEOUT_CYC));
   assign sel_we      = grant_port ? we1    : we0;
   assign sel_idx     = grant_port ? idx1   : idx0;
   assign sel_wdata   = grant_port ? wdata1 : wdata0;

   // Odd rail carries the true bit; equal rails (00 or 11) are not a valid codeword.
   always_comb begin
      rd_dec = '0;
      rd_bad = 1'b0;
      for (int k = 0; k < 8; k++) begin
         rd_dec[k] = c_data_out[2*k+1];
         if (c_data_out[2*k+1] == c_data_out[2*k]) rd_bad = 1'b1;
      end
   end

   always_comb begin
      grant_any  = req0 | req1;
      grant_port = (req0 & req1) ? ~last_grant : req1 & ~req0;
      state_next = state;
      case (state)
         S_IDLE:     if (grant_any) state_next = S_DRIVE;
         S_DRIVE:    state_next = S_WAIT_ACK;
         S_WAIT_ACK: if (ack_sel || timeout_hit) state_next = S_RTZ;
         S_RTZ:      state_next = S_WAIT_REL;
         S_WAIT_REL: if (!ack_sel || timeout_hit) state_next = S_DONE;
         S_DONE:     state_next = S_IDLE;
         default:    state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= '0;
         sync_w <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], c_ack_read};
         sync_w <= {sync_w[SYNC_STAGES-2:0], c_ack_write};
      end
   end

   // Outputs are loaded on entry to the state that owns them, so each state's
   // lines are already valid during that state (done is seen in the DONE cycle).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         last_grant    <= 1'b1;
         gnt_q         <= 1'b0;
         we_q          <= 1'b0;
         err_flag      <= 1'b0;
         cnt           <= '0;
         done0         <= 1'b0;
         done1         <= 1'b0;
         err           <= 1'b0;
         busy          <= 1'b0;
         rdata         <= '0;
         c_addr        <= '0;
         c_data_in     <= '0;
         c_read_Nwrite <= '0;
         c_ack_in_read <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != S_IDLE);
         done0 <= 1'b0;
         done1 <= 1'b0;
         err   <= 1'b0;
         case (state)
            S_IDLE: if (grant_any) begin
               last_grant    <= grant_port;
               gnt_q         <= grant_port;
               we_q          <= sel_we;
               err_flag      <= 1'b0;
               cnt           <= '0;
               c_addr        <= {sel_idx[1], ~sel_idx[1], sel_idx[0], ~sel_idx[0]};
               c_data_in     <= sel_we ? enc8(sel_wdata) : 16'h0000;
               c_read_Nwrite <= sel_we ? 2'b01 : 2'b10;
               c_ack_in_read <= 1'b0;
            end
            S_WAIT_ACK: begin
               if (ack_sel || timeout_hit) begin
                  c_addr        <= '0;
                  c_data_in     <= '0;
                  c_read_Nwrite <= '0;
                  c_ack_in_read <= ~we_q;
                  cnt           <= '0;
                  if (!ack_sel) begin
                     err_flag <= 1'b1;
                  end else if (!we_q) begin
                     rdata    <= rd_dec;
                     err_flag <= rd_bad;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WAIT_REL: begin
               if (!ack_sel || timeout_hit) begin
                  c_ack_in_read <= 1'b0;
                  done0         <= ~gnt_q;
                  done1         <= gnt_q;
                  // ack still high here means the release timed out
                  err           <= err_flag | ack_sel;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
